// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM-stage data-memory access controller.
// Contents: FSM state encoding and the default ack-watchdog timeout.
// Ports: none (package).
package mem_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Maximum cycles spent in REQ waiting for an ack; 0 disables the watchdog.
  localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/mem_stage_access_if.sv
// mem_stage_access_if: req/ack bus between the MEM-stage controller and a multi-cycle data memory.
// Signals: mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o driven by the controller (master),
//          mem_ack_i/mem_rdata_i driven by the memory (slave). Names follow the controller's view.
interface mem_stage_access_if #(
  parameter int DATA_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_ack_watchdog.sv
// mem_ack_watchdog: counts cycles spent waiting for a memory ack and flags expiry.
// Ports: clk_i, rst_i (async, active-high), clear_i (zero the count), enable_i (count this cycle),
//        expired_o (combinational: this enabled cycle is the TIMEOUT_CYC-th one; never set when TIMEOUT_CYC=0).
module mem_ack_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // The count holds the number of already-completed waiting cycles, so it only
  // needs to reach TIMEOUT_CYC-1.
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = (TIMEOUT_CYC != 0) && enable_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM-stage data-memory access controller; turns MemRead/MemWrite into a
//   req/ack transaction, stalls the pipeline until completion, presents load data to MEMWB.
// Ports: clk_i, rst_i (async, active-high); MemRead_i, MemWrite_i, Addr_i, WriteData_i from EX/MEM;
//   stall_o, MemData_o, err_o (sticky) to the pipeline; mem (master modport) to the data memory.
// Optional: define MEM_MISALIGN_CHECK_EN to reject word-misaligned accesses with err_o.
module mem_stage_access
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic [DATA_W-1:0]    Addr_i,
  input  logic [DATA_W-1:0]    WriteData_i,
  output logic                 stall_o,
  output logic [DATA_W-1:0]    MemData_o,
  output logic                 err_o,
  mem_stage_access_if.master   mem
);

  state_t            state_q;
  logic              req_q;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] memdata_q;
  logic              err_q;
  logic              access;
  logic              wd_expired;

  assign access = MemRead_i | MemWrite_i;

  // DONE deliberately drops the stall so the instruction leaves MEM exactly once.
  assign stall_o = ((state_q == S_IDLE) && access) || (state_q == S_REQ);

  mem_ack_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q != S_REQ),
    .enable_i  (state_q == S_REQ),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      memdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (access) begin
`ifdef MEM_MISALIGN_CHECK_EN
            if (Addr_i[1:0] != 2'b00) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else
`endif
            begin
              // Both strobes high is treated as a store.
              req_q   <= 1'b1;
              we_q    <= MemWrite_i;
              addr_q  <= Addr_i;
              wdata_q <= WriteData_i;
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // An ack in the expiry cycle still completes normally.
          if (mem.mem_ack_i) begin
            req_q <= 1'b0;
            if (!we_q) begin
              memdata_q <= mem.mem_rdata_i;
            end
            state_q <= S_DONE;
          end else if (wd_expired) begin
            req_q     <= 1'b0;
            err_q     <= 1'b1;
            memdata_q <= '0;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign MemData_o       = memdata_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access: self-checking bench for mem_stage_access with TIMEOUT_CYC=4.
// Expected transactions are queued when an access is driven and retired when the
// instruction leaves MEM (stall_o low); the bench also plays the data memory.
module tb_mem_stage_access;

  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct {
    logic          req;
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] md;
    logic          err;
    int            stall;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          MemRead_i = 1'b0;
  logic          MemWrite_i = 1'b0;
  logic [DW-1:0] Addr_i = '0;
  logic [DW-1:0] WriteData_i = '0;
  logic          stall_o;
  logic [DW-1:0] MemData_o;
  logic          err_o;

  mem_stage_access_if #(.DATA_W(DW)) mem_if ();

  mem_stage_access #(
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .Addr_i      (Addr_i),
    .WriteData_i (WriteData_i),
    .stall_o     (stall_o),
    .MemData_o   (MemData_o),
    .err_o       (err_o),
    .mem         (mem_if)
  );

  always #5 clk_i = ~clk_i;

  int            n_checks = 0;
  int            n_fail   = 0;
  exp_t          sb_q[$];
  logic [DW-1:0] md_model  = '0;
  logic          err_model = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one MEM-stage instruction in the next IDLE cycle and answer its request
  // with an ack in REQ cycle ack_n (0 = never ack).
  task automatic do_access(input logic rd, input logic wr, input logic [DW-1:0] addr,
                           input logic [DW-1:0] wd, input int ack_n, input logic [DW-1:0] rdata);
    exp_t e;
    int   stall_n, req_n, rise_n, req_cycles;
    logic prev, done, misal;
`ifdef MEM_MISALIGN_CHECK_EN
    misal = (addr[1:0] != 2'b00);
`else
    misal = 1'b0;
`endif
    e.req   = !misal;
    e.we    = wr;
    e.addr  = addr;
    e.wdata = wd;
    if (misal) begin
      err_model = 1'b1;
      e.stall   = 1;
    end else begin
      req_cycles = (ack_n != 0 && ack_n <= TO) ? ack_n : TO;
      e.stall    = 1 + req_cycles;
      if (ack_n == 0 || ack_n > TO) begin
        md_model  = '0;
        err_model = 1'b1;
      end else if (!wr) begin
        md_model = rdata;
      end
    end
    e.md  = md_model;
    e.err = err_model;

    @(posedge clk_i); #1;
    sb_q.push_back(e);
    MemRead_i   = rd;
    MemWrite_i  = wr;
    Addr_i      = addr;
    WriteData_i = wd;

    done = 1'b0; stall_n = 0; req_n = 0; rise_n = 0; prev = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk_i);
      if (c == 0) check("idle_req_low", {31'b0, mem_if.mem_req_o}, 32'd0);
      if (stall_o) stall_n++;
      if (mem_if.mem_req_o) begin
        req_n++;
        if (!prev) rise_n++;
        check("req_we",   {31'b0, mem_if.mem_we_o}, {31'b0, sb_q[0].we});
        check("req_addr", mem_if.mem_addr_o, sb_q[0].addr);
        if (sb_q[0].we) check("req_wdata", mem_if.mem_wdata_o, sb_q[0].wdata);
      end
      prev = mem_if.mem_req_o;
      mem_if.mem_ack_i   = mem_if.mem_req_o && (ack_n != 0) && (req_n == ack_n);
      mem_if.mem_rdata_i = rdata;
      if (!stall_o) begin
        done = 1'b1;
        e = sb_q.pop_front();
        check("memdata",    MemData_o, e.md);
        check("err",        {31'b0, err_o}, {31'b0, e.err});
        check("stall_cyc",  stall_n, e.stall);
        check("req_pulses", rise_n, e.req ? 1 : 0);
      end else begin
        @(posedge clk_i); #1;
        mem_if.mem_ack_i = 1'b0;
      end
    end
    if (!done) check("done_bound", 32'd0, 32'd1);
  endtask

  task automatic go_idle();
    @(posedge clk_i); #1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
  endtask

  initial begin
    mem_if.mem_ack_i   = 1'b0;
    mem_if.mem_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_req",   {31'b0, mem_if.mem_req_o}, 32'd0);
    check("rst_we",    {31'b0, mem_if.mem_we_o}, 32'd0);
    check("rst_addr",  mem_if.mem_addr_o, 32'd0);
    check("rst_wdata", mem_if.mem_wdata_o, 32'd0);
    check("rst_md",    MemData_o, 32'd0);
    check("rst_err",   {31'b0, err_o}, 32'd0);
    check("rst_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Load, ack in 3rd REQ cycle.
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 3, 32'h1234_5678);
    // Store, immediate ack; load data must not change.
    do_access(1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 1, 32'hFFFF_FFFF);
    go_idle();
    // Back-to-back load then store.
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 2, 32'hA5A5_0001);
    do_access(1'b0, 1'b1, 32'h104, 32'h0BAD_BEEF, 1, 32'h1111_1111);
    // Both strobes: a write.
    do_access(1'b1, 1'b1, 32'h108, 32'h2222_3333, 1, 32'h4444_5555);
    // Ack in the same cycle the watchdog would expire: ack wins.
    do_access(1'b1, 1'b0, 32'h10C, 32'h0, TO, 32'h0000_0077);
    go_idle();

    // Ack while idle is ignored.
    @(posedge clk_i); #1;
    mem_if.mem_ack_i   = 1'b1;
    mem_if.mem_rdata_i = 32'hDEAD_DEAD;
    @(negedge clk_i);
    check("stray_ack_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk_i); #1;
    mem_if.mem_ack_i = 1'b0;
    @(negedge clk_i);
    check("stray_ack_md",  MemData_o, md_model);
    check("stray_ack_req", {31'b0, mem_if.mem_req_o}, 32'd0);

    // Misaligned load.
    do_access(1'b1, 1'b0, 32'h41, 32'h0, 1, 32'h5555_AAAA);
    go_idle();
    // No ack: watchdog expiry.
    do_access(1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h9999_9999);
    go_idle();
    // err_o stays set through a normal access.
    do_access(1'b1, 1'b0, 32'h300, 32'h0, 2, 32'h0000_0ABC);

    // Reset in the middle of a request.
    @(posedge clk_i); #1;
    MemRead_i = 1'b1;
    Addr_i    = 32'h400;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("pre_rst_req", {31'b0, mem_if.mem_req_o}, 32'd1);
    #2;
    rst_i     = 1'b1;
    MemRead_i = 1'b0;
    #1;
    check("async_rst_req",   {31'b0, mem_if.mem_req_o}, 32'd0);
    check("async_rst_stall", {31'b0, stall_o}, 32'd0);
    check("async_rst_err",   {31'b0, err_o}, 32'd0);
    check("async_rst_md",    MemData_o, 32'd0);
    md_model  = '0;
    err_model = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_stall", {31'b0, stall_o}, 32'd0);
    check("post_rst_req",   {31'b0, mem_if.mem_req_o}, 32'd0);
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'h0000_0099);
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
